// File: rtl/retospect_lif_neuron.sv
// rtl/retospect_lif_neuron.sv - leaky integrate-and-fire neuron cell with serial config chain
//
// Ports:
//   clk        clock
//   rst_n      synchronous active-low reset (clears config and dynamic state)
//   config_en  high: shift the config chain one bit per cycle
//   bs_in      config chain serial input
//   bs_out     config chain serial output (cfg[0])
//   reset_nn   network reset: clears potential, refractory counter and axon
//   clockbus   decay strobes from the clock box, one selected by decay_sel
//   in_spike   input spikes, one per weight
//   axon       registered output spike, one-cycle pulse
//   potential  membrane potential, for observation
//
// Config layout, MSB to LSB: w[0] .. w[NUM_IN-1], thresh, decay_sel, refrac.

module retospect_lif_neuron #(
    parameter int NUM_IN    = 4,
    parameter int W_WIDTH   = 3,
    parameter int V_WIDTH   = 6,
    parameter int SEL_WIDTH = 3,
    parameter int REF_WIDTH = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      config_en,
    input  logic                      bs_in,
    output logic                      bs_out,
    input  logic                      reset_nn,
    input  logic [2**SEL_WIDTH-1:0]   clockbus,
    input  logic [NUM_IN-1:0]         in_spike,
    output logic                      axon,
    output logic [V_WIDTH-1:0]        potential
);

    localparam int L     = NUM_IN * W_WIDTH + V_WIDTH + SEL_WIDTH + REF_WIDTH;
    localparam int S_W   = W_WIDTH + $clog2(NUM_IN) + 1;
    localparam int RAW_W = V_WIDTH + 2;

    logic [L-1:0]           cfg;
    logic [V_WIDTH-1:0]     v;
    logic [REF_WIDTH-1:0]   ref_cnt;

    logic [V_WIDTH-1:0]     thresh;
    logic [SEL_WIDTH-1:0]   decay_sel;
    logic [REF_WIDTH-1:0]   refrac;

    logic                   decay;
    logic [V_WIDTH-1:0]     dv;
    logic signed [S_W-1:0]  sum;
    logic signed [RAW_W-1:0] raw;
    logic [V_WIDTH-1:0]     v_next;
    logic                   fire;

    assign thresh    = cfg[V_WIDTH+SEL_WIDTH+REF_WIDTH-1 : SEL_WIDTH+REF_WIDTH];
    assign decay_sel = cfg[SEL_WIDTH+REF_WIDTH-1 : REF_WIDTH];
    assign refrac    = cfg[REF_WIDTH-1:0];

    assign decay = clockbus[decay_sel];
    assign dv    = decay ? (v >> 1) : v;

    // Weights are sign-extended into a sum wide enough that all-inputs-active cannot overflow.
    always_comb begin
        sum = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (in_spike[i]) begin
                sum = sum + S_W'($signed(cfg[L-1-i*W_WIDTH -: W_WIDTH]));
            end
        end
    end

    // Two guard bits: the top one catches a negative result, the next one overflow above max.
    always_comb begin
        raw = $signed({2'b00, dv}) + RAW_W'(sum);
        if (raw[RAW_W-1]) begin
            v_next = '0;
        end else if (raw[V_WIDTH]) begin
            v_next = '1;
        end else begin
            v_next = raw[V_WIDTH-1:0];
        end
    end

    assign fire = (ref_cnt == '0) && (thresh != '0) && (v_next >= thresh);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cfg     <= '0;
            v       <= '0;
            ref_cnt <= '0;
            axon    <= 1'b0;
        end else if (reset_nn) begin
            v       <= '0;
            ref_cnt <= '0;
            axon    <= 1'b0;
        end else if (config_en) begin
            cfg     <= {bs_in, cfg[L-1:1]};
            axon    <= 1'b0;
        end else if (ref_cnt != '0) begin
            // Refractory: inputs ignored, but leak still applies.
            ref_cnt <= ref_cnt - REF_WIDTH'(1);
            v       <= dv;
            axon    <= 1'b0;
        end else if (fire) begin
            axon    <= 1'b1;
            v       <= '0;
            ref_cnt <= refrac;
        end else begin
            v       <= v_next;
            axon    <= 1'b0;
        end
    end

    assign bs_out    = cfg[0];
    assign potential = v;

endmodule

// File: tb/tb_retospect_lif_neuron.sv
// tb/tb_retospect_lif_neuron.sv - directed table-driven bench for retospect_lif_neuron

module tb_retospect_lif_neuron;

    localparam int L = 24;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       config_en;
    logic       bs_in;
    logic       bs_out;
    logic       reset_nn;
    logic [7:0] clockbus;
    logic [3:0] in_spike;
    logic       axon;
    logic [5:0] potential;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        bit          load;
        logic [23:0] cfg;
        bit          nn;
        logic [3:0]  spike;
        logic [7:0]  cb;
        bit          exp_axon;
        logic [5:0]  exp_pot;
    } vec_t;

    vec_t rows[$];

    retospect_lif_neuron dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .config_en (config_en),
        .bs_in     (bs_in),
        .bs_out    (bs_out),
        .reset_nn  (reset_nn),
        .clockbus  (clockbus),
        .in_spike  (in_spike),
        .axon      (axon),
        .potential (potential)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] mk(input logic [2:0] w0, input logic [2:0] w1,
                                       input logic [2:0] w2, input logic [2:0] w3,
                                       input logic [5:0] th, input logic [2:0] sel,
                                       input logic [2:0] rf);
        return {w0, w1, w2, w3, th, sel, rf};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_cfg(input logic [23:0] c);
        config_en = 1'b1;
        for (int i = 0; i < L; i++) begin
            bs_in = c[i];
            tick();
        end
        config_en = 1'b0;
        bs_in     = 1'b0;
    endtask

    // Shift the chain through itself, checking each bit on bs_out and restoring cfg.
    task automatic readback(input string name, input logic [23:0] c, input logic [5:0] pot);
        config_en = 1'b1;
        for (int j = 0; j < L; j++) begin
            check($sformatf("%s_bit%0d", name, j), {31'd0, bs_out}, {31'd0, c[j]});
            bs_in = c[j];
            tick();
        end
        config_en = 1'b0;
        bs_in     = 1'b0;
        check({name, "_pot_frozen"}, {26'd0, potential}, {26'd0, pot});
    endtask

    function automatic void add(input bit load, input logic [23:0] c, input bit nn,
                                input logic [3:0] sp, input logic [7:0] cb,
                                input bit ax, input logic [5:0] pot);
        vec_t r;
        r.load = load; r.cfg = c; r.nn = nn; r.spike = sp; r.cb = cb;
        r.exp_axon = ax; r.exp_pot = pot;
        rows.push_back(r);
    endfunction

    task automatic run_rows(input string name);
        for (int k = 0; k < rows.size(); k++) begin
            if (rows[k].load) load_cfg(rows[k].cfg);
            reset_nn = rows[k].nn;
            in_spike = rows[k].spike;
            clockbus = rows[k].cb;
            tick();
            check($sformatf("%s_row%0d_axon", name, k), {31'd0, axon}, {31'd0, rows[k].exp_axon});
            check($sformatf("%s_row%0d_pot", name, k), {26'd0, potential}, {26'd0, rows[k].exp_pot});
            reset_nn = 1'b0;
            in_spike = 4'b0000;
            clockbus = 8'h00;
        end
        rows.delete();
    endtask

    initial begin
        logic [23:0] pat;
        logic [23:0] c_if, c_ref, c_b2b, c_dec, c_mix;

        pat   = 24'hA5C396;
        c_if  = mk(3'b011, 3'b000, 3'b000, 3'b000, 6'd9, 3'd0, 3'd0);
        c_ref = mk(3'b011, 3'b000, 3'b000, 3'b000, 6'd9, 3'd0, 3'd2);
        c_b2b = mk(3'b011, 3'b000, 3'b000, 3'b000, 6'd3, 3'd0, 3'd0);
        c_dec = mk(3'b011, 3'b100, 3'b010, 3'b001, 6'd0, 3'd5, 3'd0);
        c_mix = mk(3'b011, 3'b110, 3'b001, 3'b000, 6'd0, 3'd0, 3'd0);

        rst_n = 1'b0; config_en = 1'b0; bs_in = 1'b0; reset_nn = 1'b0;
        clockbus = 8'h00; in_spike = 4'b0000;
        tick(); tick();
        rst_n = 1'b1;
        check("reset_axon", {31'd0, axon}, 32'd0);
        check("reset_pot", {26'd0, potential}, 32'd0);
        check("reset_bs_out", {31'd0, bs_out}, 32'd0);

        // Config shift: pattern in, then zeros push it out on bs_out in order.
        config_en = 1'b1;
        for (int i = 0; i < L; i++) begin
            bs_in = pat[i];
            tick();
        end
        for (int j = 0; j < L; j++) begin
            check($sformatf("shift_out_bit%0d", j), {31'd0, bs_out}, {31'd0, pat[j]});
            bs_in = 1'b0;
            tick();
        end
        config_en = 1'b0;
        check("shift_pot", {26'd0, potential}, 32'd0);

        // Integrate and fire, refractory, back-to-back fires.
        add(1, c_if,  0, 4'b0001, 8'h00, 0, 6'd3);
        add(0, 0,     0, 4'b0001, 8'h00, 0, 6'd6);
        add(0, 0,     0, 4'b0001, 8'h00, 1, 6'd0);
        add(0, 0,     0, 4'b0000, 8'h00, 0, 6'd0);
        add(1, c_ref, 0, 4'b0001, 8'h00, 0, 6'd3);
        add(0, 0,     0, 4'b0001, 8'h00, 0, 6'd6);
        add(0, 0,     0, 4'b0001, 8'h00, 1, 6'd0);
        add(0, 0,     0, 4'b0001, 8'h00, 0, 6'd0);
        add(0, 0,     0, 4'b0001, 8'h00, 0, 6'd0);
        add(0, 0,     0, 4'b0001, 8'h00, 0, 6'd3);
        add(0, 0,     0, 4'b0001, 8'h00, 0, 6'd6);
        add(0, 0,     0, 4'b0001, 8'h00, 1, 6'd0);
        add(0, 0,     1, 4'b0001, 8'h00, 0, 6'd0);
        add(1, c_b2b, 0, 4'b0001, 8'h00, 1, 6'd0);
        add(0, 0,     0, 4'b0001, 8'h00, 1, 6'd0);
        add(0, 0,     0, 4'b0001, 8'h00, 1, 6'd0);
        add(0, 0,     0, 4'b0000, 8'h00, 0, 6'd0);
        run_rows("fire");

        // Decay selector, clamp at 0, saturate at 63.
        add(1, c_dec, 0, 4'b1101, 8'h00, 0, 6'd6);
        for (int i = 2; i <= 6; i++) add(0, 0, 0, 4'b1101, 8'h00, 0, 6'(6 * i));
        add(0, 0, 0, 4'b0001, 8'h00, 0, 6'd39);
        add(0, 0, 0, 4'b1000, 8'h00, 0, 6'd40);
        add(0, 0, 0, 4'b0000, 8'h20, 0, 6'd20);
        add(0, 0, 0, 4'b0000, 8'h10, 0, 6'd20);
        add(0, 0, 0, 4'b0001, 8'h20, 0, 6'd13);
        add(0, 0, 0, 4'b0000, 8'h20, 0, 6'd6);
        add(0, 0, 0, 4'b0010, 8'h00, 0, 6'd2);
        add(0, 0, 0, 4'b0010, 8'h00, 0, 6'd0);
        add(0, 0, 0, 4'b0010, 8'h00, 0, 6'd0);
        for (int i = 1; i <= 10; i++) add(0, 0, 0, 4'b1101, 8'h00, 0, 6'(6 * i));
        add(0, 0, 0, 4'b0001, 8'h00, 0, 6'd63);
        add(0, 0, 0, 4'b0001, 8'h00, 0, 6'd63);
        add(0, 0, 0, 4'b1111, 8'h00, 0, 6'd63);
        add(0, 0, 0, 4'b0000, 8'h20, 0, 6'd31);
        add(0, 0, 1, 4'b0000, 8'h00, 0, 6'd0);
        run_rows("decay");

        // Mixed signs with config freeze and network reset.
        add(1, c_mix, 0, 4'b0111, 8'h00, 0, 6'd2);
        add(0, 0,     0, 4'b0111, 8'h00, 0, 6'd4);
        run_rows("mix_a");
        readback("rb_mid", c_mix, 6'd4);
        add(0, 0, 0, 4'b0111, 8'h00, 0, 6'd6);
        add(0, 0, 1, 4'b0111, 8'h00, 0, 6'd0);
        run_rows("mix_b");
        readback("rb_nn", c_mix, 6'd0);
        add(0, 0, 0, 4'b0111, 8'h00, 0, 6'd2);
        run_rows("mix_c");

        // Hard reset clears config too.
        rst_n = 1'b0; in_spike = 4'b0111;
        tick();
        rst_n = 1'b1; in_spike = 4'b0000;
        check("rst_axon", {31'd0, axon}, 32'd0);
        check("rst_pot", {26'd0, potential}, 32'd0);
        check("rst_bs_out", {31'd0, bs_out}, 32'd0);
        readback("rb_rst", 24'd0, 6'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
